issp_engine: RTL and testbench

- Parametrised successor of the fixed 22-bit M8C ISSP sequencer.
- A single-clock engine that executes ISSP commands against a Cypress M8C/M7C device: POR, power-off, EXEC handshake, vector send, and vector read-back.
- It adds configurable vector length, a read/turnaround phase, wait timeouts with an error flag, and abort.
- It sits between the TOP2049 bus register file (wrapper, not part of this block) and the ZIF pin buffers.

---
 rtl/issp_engine.sv | 279 +++++++++++++++++++++++++++
 tb/tb_issp_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/issp_engine.sv
// ISSP command sequencer for Cypress M8C/M7C devices: POR, power-off, EXEC handshake,
// MSB-first vector send and SDATA read-back, with wait timeouts, error flag and abort.
module issp_engine #(
  parameter int VEC_MAX   = 32,
  parameter int RX_MAX    = 16,
  parameter int HALF_CYC  = 6,
  parameter int VDD_WAIT  = 24000,
  parameter int POLL_CYC  = 24,
  parameter int POLL_CNT  = 10,
  parameter int PRE_CLKS  = 33,
  parameter int POST_CLKS = 50,
  parameter int WAIT_TMO  = 48000,
  localparam int VL_W     = $clog2(VEC_MAX + 1),
  localparam int RL_W     = $clog2(RX_MAX + 1)
) (
  input  logic               osc,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd,
  input  logic [VEC_MAX-1:0] vec_out,
  input  logic [VL_W-1:0]    vec_len,
  input  logic [RL_W-1:0]    rx_len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RX_MAX-1:0]  rx_data,
  input  logic               sdata_in,
  output logic               sdata_out,
  output logic               sdata_oe,
  output logic               sclk_out,
  output logic               sclk_oe,
  output logic               vdd_en
);
  localparam int CNT_A   = (VDD_WAIT > WAIT_TMO) ? VDD_WAIT : WAIT_TMO;
  localparam int CNT_MAX = (CNT_A > POLL_CYC) ? CNT_A : POLL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CK_A    = (PRE_CLKS > POST_CLKS) ? PRE_CLKS : POST_CLKS;
  localparam int CK_MAX  = (CK_A > RX_MAX) ? CK_A : RX_MAX;
  localparam int CK_W    = $clog2(CK_MAX + 1);
  localparam int HC_W    = $clog2(HALF_CYC + 1);
  localparam int PC_W    = $clog2(POLL_CNT + 1);

  localparam logic [2:0] CMD_POR = 3'd1, CMD_PWROFF = 3'd2, CMD_EXEC = 3'd3,
                         CMD_SEND = 3'd4, CMD_READ = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_POR_VDD, S_POR_LOW, S_SHIFT_HI, S_SHIFT_LO, S_SHIFT_DONE,
    S_EXEC_POLL, S_EXEC_WAIT, S_CLK_HI, S_CLK_LO, S_FINISH
  } state_t;

  typedef enum logic [1:0] {PH_PRE, PH_POST, PH_TURN, PH_RX} phase_t;

  state_t             state_reg;
  phase_t             phase_reg;
  logic [VEC_MAX-1:0] vec_reg;
  logic [VL_W-1:0]    bit_cnt_reg;
  logic [RL_W-1:0]    rx_len_reg;
  logic               is_read_reg;
  logic [CNT_W-1:0]   cyc_cnt_reg;
  logic [HC_W-1:0]    half_cnt_reg;
  logic [CK_W-1:0]    clk_cnt_reg;
  logic [PC_W-1:0]    poll_cnt_reg;
  logic               sync1_reg, sdata_s_reg;
  logic [VL_W-1:0]    len_c;
  logic [RL_W-1:0]    rx_c;

  always_comb begin
    len_c = (vec_len > VL_W'(VEC_MAX)) ? VL_W'(VEC_MAX) : vec_len;
    rx_c  = (rx_len > RL_W'(RX_MAX)) ? RL_W'(RX_MAX) : rx_len;
  end

  // Primitives are entered through their low phase with an expired half counter,
  // so a zero-length request falls straight through to the completion branch.
  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      phase_reg    <= PH_PRE;
      vec_reg      <= '0;
      bit_cnt_reg  <= '0;
      rx_len_reg   <= '0;
      is_read_reg  <= 1'b0;
      cyc_cnt_reg  <= '0;
      half_cnt_reg <= '0;
      clk_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
      sync1_reg    <= 1'b0;
      sdata_s_reg  <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rx_data      <= '0;
      sdata_out    <= 1'b0;
      sdata_oe     <= 1'b0;
      sclk_out     <= 1'b0;
      sclk_oe      <= 1'b0;
      vdd_en       <= 1'b0;
    end else begin
      sync1_reg   <= sdata_in;
      sdata_s_reg <= sync1_reg;
      done        <= 1'b0;
      if (busy && abort) begin
        vdd_en    <= 1'b0;
        sdata_oe  <= 1'b0;
        sclk_oe   <= 1'b0;
        sclk_out  <= 1'b0;
        sdata_out <= 1'b0;
        err       <= 1'b1;
        done      <= 1'b1;
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: if (cmd_valid && !abort) begin
            vec_reg      <= vec_out << (VL_W'(VEC_MAX) - len_c);
            bit_cnt_reg  <= len_c;
            rx_len_reg   <= rx_c;
            is_read_reg  <= (cmd == CMD_READ);
            err          <= 1'b0;
            half_cnt_reg <= '0;
            case (cmd)
              CMD_POR: begin
                vdd_en      <= 1'b1;
                sclk_oe     <= 1'b1;
                sclk_out    <= 1'b0;
                sdata_oe    <= 1'b0;
                cyc_cnt_reg <= CNT_W'(VDD_WAIT - 1);
                busy        <= 1'b1;
                cmd_ready   <= 1'b0;
                state_reg   <= S_POR_VDD;
              end
              CMD_PWROFF: begin
                vdd_en    <= 1'b0;
                sdata_oe  <= 1'b0;
                sclk_oe   <= 1'b0;
                sclk_out  <= 1'b0;
                sdata_out <= 1'b0;
                done      <= 1'b1;
              end
              CMD_EXEC: begin
                sclk_oe      <= 1'b1;
                sclk_out     <= 1'b0;
                sdata_oe     <= 1'b0;
                poll_cnt_reg <= PC_W'(POLL_CNT);
                cyc_cnt_reg  <= CNT_W'(POLL_CYC - 1);
                busy         <= 1'b1;
                cmd_ready    <= 1'b0;
                state_reg    <= S_EXEC_POLL;
              end
              CMD_SEND, CMD_READ: begin
                if (cmd == CMD_READ) rx_data <= '0;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                state_reg <= S_SHIFT_LO;
              end
              default: done <= 1'b1;
            endcase
          end
          S_POR_VDD: begin
            if (cyc_cnt_reg == '0) begin
              cyc_cnt_reg <= CNT_W'(WAIT_TMO - 1);
              state_reg   <= S_POR_LOW;
            end else cyc_cnt_reg <= cyc_cnt_reg - CNT_W'(1);
          end
          S_POR_LOW: begin
            if (!sdata_s_reg) begin
              half_cnt_reg <= '0;
              state_reg    <= S_SHIFT_LO;
            end else if (cyc_cnt_reg == '0) begin
              err       <= 1'b1;
              state_reg <= S_FINISH;
            end else cyc_cnt_reg <= cyc_cnt_reg - CNT_W'(1);
          end
          S_SHIFT_HI: begin
            if (half_cnt_reg == '0) begin
              sclk_out     <= 1'b0;
              half_cnt_reg <= HC_W'(HALF_CYC - 1);
              state_reg    <= S_SHIFT_LO;
            end else half_cnt_reg <= half_cnt_reg - HC_W'(1);
          end
          S_SHIFT_LO: begin
            if (half_cnt_reg != '0) half_cnt_reg <= half_cnt_reg - HC_W'(1);
            else if (bit_cnt_reg == '0) state_reg <= S_SHIFT_DONE;
            else begin
              sdata_oe     <= 1'b1;
              sdata_out    <= vec_reg[VEC_MAX-1];
              vec_reg      <= vec_reg << 1;
              bit_cnt_reg  <= bit_cnt_reg - VL_W'(1);
              sclk_out     <= 1'b1;
              half_cnt_reg <= HC_W'(HALF_CYC - 1);
              state_reg    <= S_SHIFT_HI;
            end
          end
          S_SHIFT_DONE: begin
            if (is_read_reg) begin
              sdata_oe     <= 1'b0;
              clk_cnt_reg  <= CK_W'(1);
              phase_reg    <= PH_TURN;
              half_cnt_reg <= '0;
              state_reg    <= S_CLK_LO;
            end else state_reg <= S_FINISH;
          end
          S_EXEC_POLL: begin
            if (cyc_cnt_reg != '0) cyc_cnt_reg <= cyc_cnt_reg - CNT_W'(1);
            else if (sdata_s_reg) begin
              cyc_cnt_reg <= CNT_W'(WAIT_TMO - 1);
              state_reg   <= S_EXEC_WAIT;
            end else if (poll_cnt_reg <= PC_W'(1)) begin
              clk_cnt_reg  <= CK_W'(PRE_CLKS);
              phase_reg    <= PH_PRE;
              half_cnt_reg <= '0;
              state_reg    <= S_CLK_LO;
            end else begin
              poll_cnt_reg <= poll_cnt_reg - PC_W'(1);
              cyc_cnt_reg  <= CNT_W'(POLL_CYC - 1);
            end
          end
          S_EXEC_WAIT: begin
            if (!sdata_s_reg) begin
              clk_cnt_reg  <= CK_W'(POST_CLKS);
              phase_reg    <= PH_POST;
              half_cnt_reg <= '0;
              state_reg    <= S_CLK_LO;
            end else if (cyc_cnt_reg == '0) begin
              err       <= 1'b1;
              state_reg <= S_FINISH;
            end else cyc_cnt_reg <= cyc_cnt_reg - CNT_W'(1);
          end
          S_CLK_HI: begin
            if (half_cnt_reg == '0) begin
              if (phase_reg == PH_RX) rx_data <= {rx_data[RX_MAX-2:0], sdata_s_reg};
              sclk_out     <= 1'b0;
              half_cnt_reg <= HC_W'(HALF_CYC - 1);
              state_reg    <= S_CLK_LO;
            end else half_cnt_reg <= half_cnt_reg - HC_W'(1);
          end
          S_CLK_LO: begin
            if (half_cnt_reg != '0) half_cnt_reg <= half_cnt_reg - HC_W'(1);
            else if (clk_cnt_reg != '0) begin
              clk_cnt_reg  <= clk_cnt_reg - CK_W'(1);
              sclk_out     <= 1'b1;
              half_cnt_reg <= HC_W'(HALF_CYC - 1);
              state_reg    <= S_CLK_HI;
            end else begin
              case (phase_reg)
                PH_PRE: begin
                  if (sdata_s_reg) begin
                    cyc_cnt_reg <= CNT_W'(WAIT_TMO - 1);
                    state_reg   <= S_EXEC_WAIT;
                  end else begin
                    clk_cnt_reg <= CK_W'(POST_CLKS);
                    phase_reg   <= PH_POST;
                  end
                end
                PH_TURN: begin
                  clk_cnt_reg <= CK_W'(rx_len_reg);
                  phase_reg   <= PH_RX;
                end
                default: state_reg <= S_FINISH;
              endcase
            end
          end
          S_FINISH: begin
            sdata_oe  <= 1'b0;
            sclk_out  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_issp_engine.sv
// Scoreboard bench for issp_engine: commands push expected completions, a monitor checks
// SCLK pulses, driven SDATA bits, read-back data and err at every done pulse.
module tb_issp_engine;
  localparam int VDD_W = 300;
  localparam int TMO   = 1000;
  localparam int HALF  = 6;

  logic        osc = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd = 3'd0;
  logic [31:0] vec_out = '0;
  logic [5:0]  vec_len = '0;
  logic [4:0]  rx_len = '0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] rx_data;
  logic        sdata_in;
  logic        sdata_out, sdata_oe, sclk_out, sclk_oe, vdd_en;

  logic        sdata_stim = 1'b1;
  logic        rd_active = 1'b0;
  logic        rd_drive = 1'b0;
  logic [7:0]  rx_pat = 8'hC6;
  int          rd_idx = 0;
  logic        chk_bits = 1'b1;

  assign sdata_in = rd_active ? rd_drive : sdata_stim;

  issp_engine #(.VDD_WAIT(VDD_W), .WAIT_TMO(TMO)) dut (
    .osc(osc), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .vec_out(vec_out), .vec_len(vec_len), .rx_len(rx_len), .abort(abort), .busy(busy),
    .done(done), .err(err), .rx_data(rx_data), .sdata_in(sdata_in), .sdata_out(sdata_out),
    .sdata_oe(sdata_oe), .sclk_out(sclk_out), .sclk_oe(sclk_oe), .vdd_en(vdd_en)
  );

  always #5 osc = ~osc;

  typedef struct {
    string       name;
    logic        e_err;
    logic        chk_rx;
    logic [15:0] e_rx;
    logic        chk_p;
    int          pulses;
    int          base;
  } exp_t;

  exp_t sb[$];
  logic bitq[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;
  int   total_pulses = 0;
  int   hi_len = 0;
  logic sclk_prev = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input string n, input logic e, input logic crx, input logic [15:0] rx,
                              input logic cp, input int p);
    exp_t x;
    x.name = n; x.e_err = e; x.chk_rx = crx; x.e_rx = rx; x.chk_p = cp; x.pulses = p; x.base = 0;
    return x;
  endfunction

  // Monitor: SCLK pulse count/width, driven bits, device read model, done scoreboard.
  always @(negedge osc) begin
    if (sclk_out && !sclk_prev) begin
      total_pulses++;
      if (sdata_oe && chk_bits) begin
        if (bitq.size() == 0) check("unexpected_driven_bit", 32'(sdata_out), 32'hFFFF_FFFF);
        else check("sdata_bit", 32'(sdata_out), 32'(bitq.pop_front()));
      end
      if (!sdata_oe && rd_active) begin
        if (rd_idx >= 1 && rd_idx <= 8) rd_drive = rx_pat[8 - rd_idx];
        rd_idx++;
      end
    end
    if (!rd_active) rd_idx = 0;
    if (sclk_out) hi_len++;
    else begin
      if (sclk_prev && busy) check("sclk_high_len", 32'(hi_len), 32'(HALF));
      hi_len = 0;
    end
    sclk_prev = sclk_out;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 32'(done), 32'(0));
      else begin
        cur = sb.pop_front();
        check({cur.name, "_err"}, 32'(err), 32'(cur.e_err));
        if (cur.chk_rx) check({cur.name, "_rx_data"}, 32'(rx_data), 32'(cur.e_rx));
        if (cur.chk_p) check({cur.name, "_pulses"}, 32'(total_pulses - cur.base), 32'(cur.pulses));
        check({cur.name, "_bits_left"}, 32'(bitq.size()), 32'(0));
        $display("txn %s: done err=%0b rx_data=0x%0h sclk_pulses=%0d", cur.name, err, rx_data,
                 total_pulses - cur.base);
      end
    end
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] v, input int vl, input int rl,
                       input exp_t e);
    int t = 0;
    while (!cmd_ready && t < 5000) begin @(negedge osc); t++; end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'(1));
    cmd = c; vec_out = v; vec_len = 6'(vl); rx_len = 5'(rl); cmd_valid = 1'b1;
    e.base = total_pulses;
    sb.push_back(e);
    @(posedge osc);
    @(negedge osc);
    cmd_valid = 1'b0; cmd = 3'd0; vec_out = '1; vec_len = '1; rx_len = '1;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 20000) begin @(negedge osc); t++; end
    check({name, "_completed"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(0));
    check({tag, "_outs"}, 32'({sdata_out, sdata_oe, sclk_out, sclk_oe, vdd_en}), 32'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge osc);
    @(negedge osc);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge osc);

    issue(3'd0, 32'h0, 0, 0, mk("nop", 1'b0, 1'b0, 16'h0, 1'b1, 0));
    check("nop_busy", 32'(busy), 32'(0));
    wait_done("nop");

    // abort in the same cycle as a command while idle: not accepted, no done
    cmd = 3'd0; cmd_valid = 1'b1; abort = 1'b1;
    @(posedge osc); @(negedge osc);
    cmd_valid = 1'b0; abort = 1'b0;
    check("abort_idle_done", 32'(done), 32'(0));
    check("abort_idle_ready", 32'(cmd_ready), 32'(1));

    // POR with device releasing SDATA low 100 cycles after the VDD wait
    sdata_stim = 1'b1;
    push_bits(32'h2A5A5A, 22);
    issue(3'd1, 32'h2A5A5A, 22, 0, mk("por", 1'b0, 1'b0, 16'h0, 1'b1, 22));
    check("por_vdd_en", 32'(vdd_en), 32'(1));
    check("por_sclk_oe", 32'(sclk_oe), 32'(1));
    check("por_busy_ready", 32'({busy, cmd_ready}), 32'(2'b10));
    repeat (VDD_W + 99) @(negedge osc);
    sdata_stim = 1'b0;
    wait_done("por");

    // POR timeout with SDATA held high
    sdata_stim = 1'b1;
    issue(3'd1, 32'h1F, 5, 0, mk("por_tmo", 1'b1, 1'b0, 16'h0, 1'b1, 0));
    n = 1;
    while (!done && n < 3000) begin @(negedge osc); n++; end
    check("por_tmo_latency_in_window", 32'(n >= VDD_W + TMO && n <= VDD_W + TMO + 3), 32'(1));
    wait_done("por_tmo");

    issue(3'd2, 32'h0, 0, 0, mk("pwroff", 1'b0, 1'b0, 16'h0, 1'b1, 0));
    check("pwroff_outs", 32'({vdd_en, sclk_oe, sdata_oe, sclk_out}), 32'(0));
    wait_done("pwroff");

    // EXEC, SDATA stuck low: all polls fail, 33 pre-clocks then 50 post-clocks
    sdata_stim = 1'b0;
    issue(3'd3, 32'h0, 0, 0, mk("exec_low", 1'b0, 1'b0, 16'h0, 1'b1, 83));
    wait_done("exec_low");

    // EXEC, SDATA high before poll 3 then low 500 cycles later
    issue(3'd3, 32'h0, 0, 0, mk("exec_hs", 1'b0, 1'b0, 16'h0, 1'b1, 50));
    repeat (54) @(negedge osc);
    sdata_stim = 1'b1;
    repeat (500) @(negedge osc);
    sdata_stim = 1'b0;
    wait_done("exec_hs");

    // READ: 11 bits out, turnaround, 8 bits 0xC6 back
    rd_active = 1'b1;
    push_bits(32'h5A3, 11);
    issue(3'd5, 32'h5A3, 11, 8, mk("read", 1'b0, 1'b1, 16'h00C6, 1'b1, 20));
    wait_done("read");
    rd_active = 1'b0;

    // SEND 32 aborted mid-shift, then a SEND that clears err
    chk_bits = 1'b0;
    issue(3'd4, 32'hF0F0_A5A5, 32, 0, mk("send_abort", 1'b1, 1'b0, 16'h0, 1'b0, 0));
    repeat (100) @(negedge osc);
    abort = 1'b1;
    @(posedge osc); @(negedge osc);
    abort = 1'b0;
    check("abort_outs", 32'({vdd_en, sdata_oe, sclk_oe}), 32'(0));
    check("abort_err_done", 32'({err, done}), 32'(2'b11));
    wait_done("send_abort");
    chk_bits = 1'b1;
    push_bits(32'hA, 4);
    issue(3'd4, 32'hA, 4, 0, mk("send4", 1'b0, 1'b0, 16'h0, 1'b1, 4));
    check("send4_err_cleared", 32'(err), 32'(0));
    wait_done("send4");

    // Reset during EXEC post-clocks
    sdata_stim = 1'b0;
    issue(3'd3, 32'h0, 0, 0, mk("exec_rst", 1'b0, 1'b0, 16'h0, 1'b0, 0));
    repeat (700) @(negedge osc);
    check("exec_rst_in_post_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(posedge osc); @(negedge osc);
    rst_n = 1'b1;
    sb.delete();
    bitq.delete();
    check_reset_outputs("midrst");
    issue(3'd0, 32'h0, 0, 0, mk("nop_after_rst", 1'b0, 1'b0, 16'h0, 1'b1, 0));
    wait_done("nop_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
